// File: rtl/set_scan_ctrl_pkg.sv
// Shared PE field macros plus set-operation and FSM encodings for set_scan_ctrl.
// Optional build macro SET_SCAN_CTRL_PIPE_EN (used by set_scan_ctrl.sv) adds the DRAIN stage.
`ifndef SET_SCAN_CTRL_DEFS
`define SET_SCAN_CTRL_DEFS
`define AXIS_SZ    4
`define COORD_SZ   8
`define CENTRAL_SZ 24
`define RADIUS_SZ  12
`define COVERED_SZ 3
`define COORD_X    7:4
`define COORD_Y    3:0
`define CENT_A_X   23:20
`define CENT_A_Y   19:16
`define CENT_B_X   15:12
`define CENT_B_Y   11:8
`define CENT_C_X   7:4
`define CENT_C_Y   3:0
`define RAD_A      11:8
`define RAD_B      7:4
`define RAD_C      3:0
`endif

package set_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_A   = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_TWO = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Point is covered when its squared Euclidean distance to the centre is within r^2.
  function automatic logic in_circle(input logic [`AXIS_SZ-1:0] px,
                                     input logic [`AXIS_SZ-1:0] py,
                                     input logic [`AXIS_SZ-1:0] cx,
                                     input logic [`AXIS_SZ-1:0] cy,
                                     input logic [`AXIS_SZ-1:0] r);
    logic [`AXIS_SZ-1:0] dx;
    logic [`AXIS_SZ-1:0] dy;
    logic [9:0]          dxw;
    logic [9:0]          dyw;
    logic [9:0]          rw;
    logic [9:0]          d2;
    logic [9:0]          r2;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    dxw = {6'd0, dx};
    dyw = {6'd0, dy};
    rw  = {6'd0, r};
    d2  = dxw * dxw + dyw * dyw;
    r2  = rw * rw;
    return (d2 <= r2);
  endfunction

endpackage

// File: rtl/set_cover_pe.sv
// Three-circle coverage PE: reports which of circles A/B/C contain the presented point.
// covered_o = {a, b, c}; purely combinational.
module set_cover_pe
  import set_scan_ctrl_pkg::*;
(
  input  logic [`COORD_SZ-1:0]   coord_i,
  input  logic [`CENTRAL_SZ-1:0] cent_buf_i,
  input  logic [`RADIUS_SZ-1:0]  r_buf_i,
  output logic [`COVERED_SZ-1:0] covered_o
);

  always_comb begin
    covered_o    = '0;
    covered_o[2] = in_circle(coord_i[`COORD_X], coord_i[`COORD_Y],
                             cent_buf_i[`CENT_A_X], cent_buf_i[`CENT_A_Y], r_buf_i[`RAD_A]);
    covered_o[1] = in_circle(coord_i[`COORD_X], coord_i[`COORD_Y],
                             cent_buf_i[`CENT_B_X], cent_buf_i[`CENT_B_Y], r_buf_i[`RAD_B]);
    covered_o[0] = in_circle(coord_i[`COORD_X], coord_i[`COORD_Y],
                             cent_buf_i[`CENT_C_X], cent_buf_i[`CENT_C_Y], r_buf_i[`RAD_C]);
  end

endmodule

// File: rtl/set_scan_ctrl_classify.sv
// set_classify: maps the PE coverage vector {a,b,c} to a hit bit for the selected set operation.
module set_classify
  import set_scan_ctrl_pkg::*;
(
  input  mode_e                  mode,
  input  logic [`COVERED_SZ-1:0] covered,
  output logic                   hit
);

  logic a;
  logic b;
  logic c;

  assign a = covered[2];
  assign b = covered[1];
  assign c = covered[0];

  always_comb begin
    hit = 1'b0;
    case (mode)
      MODE_A:   hit = a;
      MODE_AND: hit = a & b;
      MODE_XOR: hit = a ^ b;
      MODE_TWO: hit = (a & b & ~c) | (a & ~b & c) | (~a & b & c);
      default:  hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: sweeps the grid through one coverage PE and counts points hit by the set operation.
// SET_SCAN_CTRL_PIPE_EN adds a register after the PE and a one-cycle DRAIN state.
//
// state | meaning
// IDLE  | waiting for en_i; busy_o low
// SCAN  | one grid point per cycle, x inner loop
// DRAIN | last registered PE result accumulated (pipelined build only)
// DONE  | valid_o pulse, candidate_o holds the count
module set_scan_ctrl
  import set_scan_ctrl_pkg::*;
#(
  parameter int GRID_MIN = 1,
  parameter int GRID_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [`CENTRAL_SZ-1:0] central_i,
  input  logic [`RADIUS_SZ-1:0]  radius_i,
  input  logic [1:0]             mode_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [CNT_W-1:0]       candidate_o
);

  localparam logic [`AXIS_SZ-1:0] AX_MIN = `AXIS_SZ'(GRID_MIN);
  localparam logic [`AXIS_SZ-1:0] AX_MAX = `AXIS_SZ'(GRID_MAX);

  state_e                  state_q;
  state_e                  state_d;
  logic                    start;
  logic [`AXIS_SZ-1:0]     x_q;
  logic [`AXIS_SZ-1:0]     y_q;
  logic [`CENTRAL_SZ-1:0]  cent_q;
  logic [`RADIUS_SZ-1:0]   rad_q;
  mode_e                   mode_q;
  logic [CNT_W-1:0]        acc_q;
  logic [CNT_W-1:0]        acc_sum;
  logic [CNT_W-1:0]        cand_q;
  logic [`COVERED_SZ-1:0]  covered;
  logic [`COVERED_SZ-1:0]  cov_cls;
  logic                    acc_en;
  logic                    hit;
  logic                    last_pt;

  set_cover_pe u_pe (
    .coord_i    ({x_q, y_q}),
    .cent_buf_i (cent_q),
    .r_buf_i    (rad_q),
    .covered_o  (covered)
  );

`ifdef SET_SCAN_CTRL_PIPE_EN
  logic [`COVERED_SZ-1:0] cov_q;
  logic                   cov_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cov_q     <= '0;
      cov_vld_q <= 1'b0;
    end else begin
      cov_q     <= covered;
      cov_vld_q <= (state_q == SCAN);
    end
  end

  assign cov_cls = cov_q;
  assign acc_en  = cov_vld_q;
`else
  assign cov_cls = covered;
  assign acc_en  = (state_q == SCAN);
`endif

  set_classify u_classify (
    .mode    (mode_q),
    .covered (cov_cls),
    .hit     (hit)
  );

  assign acc_sum = acc_q + {{(CNT_W-1){1'b0}}, hit & acc_en};
  assign last_pt = (x_q == AX_MAX) && (y_q == AX_MAX);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          start   = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last_pt) begin
`ifdef SET_SCAN_CTRL_PIPE_EN
          state_d = DRAIN;
`else
          state_d = DONE;
`endif
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= AX_MIN;
      y_q     <= AX_MIN;
      cent_q  <= '0;
      rad_q   <= '0;
      mode_q  <= MODE_A;
      acc_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cent_q <= central_i;
        rad_q  <= radius_i;
        mode_q <= mode_e'(mode_i);
        acc_q  <= '0;
        x_q    <= AX_MIN;
        y_q    <= AX_MIN;
      end else begin
        acc_q <= acc_sum;
        if (state_q == SCAN) begin
          if (last_pt) begin
            x_q <= AX_MIN;
            y_q <= AX_MIN;
          end else if (x_q == AX_MAX) begin
            x_q <= AX_MIN;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
      end
      // Load the final sum (including the last point) as DONE is entered.
      if (state_d == DONE) begin
        cand_q <= acc_sum;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign valid_o     = (state_q == DONE);
  assign candidate_o = cand_q;

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Scoreboard bench for set_scan_ctrl: directed jobs push expected counts/cycles, a monitor checks valid_o.
module tb_set_scan_ctrl;

  localparam int CNT_W = 8;
`ifdef SET_SCAN_CTRL_PIPE_EN
  localparam int LAT = 66;
`else
  localparam int LAT = 65;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en_i = 1'b0;
  logic [23:0]      central_i = '0;
  logic [11:0]      radius_i = '0;
  logic [1:0]       mode_i = '0;
  logic             busy_o;
  logic             valid_o;
  logic [CNT_W-1:0] candidate_o;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int jobs = 0;

  typedef struct {
    int cnt;
    int cyc;
    int id;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  set_scan_ctrl #(.GRID_MIN(1), .GRID_MAX(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .central_i   (central_i),
    .radius_i    (radius_i),
    .mode_i      (mode_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .candidate_o (candidate_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) begin
      pulses++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid cycle=%0d candidate=%0d required=no pulse", cyc, candidate_o);
      end else begin
        e = sb.pop_front();
        if (int'(candidate_o) != e.cnt || cyc != e.cyc) begin
          fails++;
          $display("FAIL job%0d_result count=%0d cycle=%0d required count=%0d cycle=%0d",
                   e.id, candidate_o, cyc, e.cnt, e.cyc);
        end
      end
    end
  end

  task automatic start_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input int exp_cnt, input bit push, output int c0);
    exp_t x;
    @(negedge clk);
    central_i = c;
    radius_i  = r;
    mode_i    = m;
    en_i      = 1'b1;
    c0        = cyc;
    if (push) begin
      x.cnt = exp_cnt;
      x.cyc = c0 + LAT;
      x.id  = jobs;
      sb.push_back(x);
      jobs++;
    end
    @(negedge clk);
    en_i      = 1'b0;
    central_i = 24'($urandom);
    radius_i  = 12'($urandom);
    mode_i    = 2'($urandom);
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start busy=%0b required=1", busy_o);
    end
  endtask

  task automatic wait_idle(input int c0);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy_o) begin
      fails++;
      $display("FAIL busy_timeout busy=%0b required=0 within 200 cycles", busy_o);
    end else if (cyc != c0 + LAT + 1) begin
      fails++;
      $display("FAIL busy_fall_cycle cycle=%0d required=%0d", cyc - c0, LAT + 1);
    end
  endtask

  task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input int exp_cnt);
    int c0;
    start_job(c, r, m, exp_cnt, 1'b1, c0);
    wait_idle(c0);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d required=finish before timeout", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests += 3;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b required=0", busy_o); end
    if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b required=0", valid_o); end
    if (candidate_o !== '0) begin fails++; $display("FAIL reset_candidate got=%0d required=0", candidate_o); end

    // {Ax,Ay,Bx,By,Cx,Cy}, {rA,rB,rC}, mode, expected count
    run_job(24'h44FFFF, 12'h200, 2'd0, 13);
    run_job(24'h44FFFF, 12'h200, 2'd1, 0);
    run_job(24'h4444FF, 12'h220, 2'd1, 13);
    run_job(24'h4444FF, 12'h220, 2'd2, 0);
    run_job(24'h44FFFF, 12'h800, 2'd0, 64);
    run_job(24'h44FFFF, 12'h000, 2'd0, 1);
    run_job(24'h444444, 12'h222, 2'd3, 0);
    run_job(24'h4444FF, 12'h220, 2'd3, 13);
    run_job(24'h4464FF, 12'h210, 2'd1, 2);
    run_job(24'h4464FF, 12'h210, 2'd2, 14);

    // en_i while busy (mid-scan and in DONE) must be ignored; then back-to-back start.
    start_job(24'h44FFFF, 12'h200, 2'd0, 13, 1'b1, c0);
    wait_until(c0 + 10);
    central_i = 24'h44FFFF; radius_i = 12'h800; mode_i = 2'd0; en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    wait_until(c0 + LAT);
    central_i = 24'h444444; radius_i = 12'h888; mode_i = 2'd0; en_i = 1'b1;
    start_job(24'h4464FF, 12'h210, 2'd2, 14, 1'b1, c1);
    tests++;
    if (c1 != c0 + LAT + 1) begin
      fails++;
      $display("FAIL back_to_back_start offset=%0d required=%0d", c1 - c0, LAT + 1);
    end
    wait_idle(c1);

    // Reset mid-job: no pulse, outputs clear on the next cycle.
    start_job(24'h44FFFF, 12'h800, 2'd0, 0, 1'b0, c0);
    wait_until(c0 + 30);
    rst = 1'b1;
    @(negedge clk);
    tests += 2;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_busy got=%0b required=0", busy_o); end
    if (candidate_o !== '0) begin fails++; $display("FAIL abort_candidate got=%0d required=0", candidate_o); end
    rst = 1'b0;
    repeat (80) @(negedge clk);
    run_job(24'h4444FF, 12'h220, 2'd3, 13);

    repeat (5) @(negedge clk);
    tests += 2;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_results left=%0d required=0", sb.size());
    end
    if (pulses != jobs) begin
      fails++;
      $display("FAIL pulse_count got=%0d required=%0d", pulses, jobs);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
